// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: write-back select codes, load size codes and
// the MEM/WB halt FSM states.
package pipeline_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // bhw[1:0] size field; any code with bit 1 set is a full word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int         BHW_UNSIGNED = 2;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } halt_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bundle: MEM-side results and controls in, write-back port out.
interface mem_wb_stage_if #(
  parameter int INST_SZ = 32,
  parameter int REG_SZ  = 5
);
  logic               i_enable;
  logic               i_flush;
  logic [INST_SZ-1:0] i_alu_result_M;
  logic [INST_SZ-1:0] i_read_data_M;
  logic [INST_SZ-1:0] i_pc_plus4_M;
  logic [REG_SZ-1:0]  i_rd_M;
  logic               i_reg_write_M;
  logic [1:0]         i_mem_to_reg_M;
  logic [2:0]         i_bhw_M;
  logic               i_halt_M;
  logic [INST_SZ-1:0] o_write_data_W;
  logic [REG_SZ-1:0]  o_rd_W;
  logic               o_reg_write_W;
  logic               o_halt_W;

  modport master (
    output i_enable, i_flush, i_alu_result_M, i_read_data_M, i_pc_plus4_M,
           i_rd_M, i_reg_write_M, i_mem_to_reg_M, i_bhw_M, i_halt_M,
    input  o_write_data_W, o_rd_W, o_reg_write_W, o_halt_W
  );

  modport slave (
    input  i_enable, i_flush, i_alu_result_M, i_read_data_M, i_pc_plus4_M,
           i_rd_M, i_reg_write_M, i_mem_to_reg_M, i_bhw_M, i_halt_M,
    output o_write_data_W, o_rd_W, o_reg_write_W, o_halt_W
  );
endinterface

// File: rtl/load_extend.sv
// Picks the byte/half/word lane out of a raw memory word and sign- or
// zero-extends it. Purely combinational so MEM forwarding can reuse it.
module load_extend
  import pipeline_pkg::*;
#(
  parameter int INST_SZ = 32
) (
  input  logic [INST_SZ-1:0] word_i,
  input  logic [1:0]         lane_i,
  input  logic [2:0]         bhw_i,
  output logic [INST_SZ-1:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_signed;

  assign is_signed = ~bhw_i[BHW_UNSIGNED];

  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  // half-word ignores lane bit 0: no misalignment trap in this pipeline
  assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    ext_o = word_i;
    if (bhw_i[1]) begin
      ext_o = word_i;
    end else if (bhw_i[1:0] == SZ_HALF) begin
      ext_o = {{(INST_SZ-16){half_sel[15] & is_signed}}, half_sel};
    end else begin
      ext_o = {{(INST_SZ-8){byte_sel[7] & is_signed}}, byte_sel};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, write-back select and a
// sticky halt tracker that freezes the stage once HALT retires.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int INST_SZ = 32,
  parameter int REG_SZ  = 5
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mem_wb_stage_if.slave  bus
);

  logic [INST_SZ-1:0] alu_result_q;
  logic [INST_SZ-1:0] read_data_q;
  logic [INST_SZ-1:0] pc_plus4_q;
  logic [REG_SZ-1:0]  rd_q;
  logic               reg_write_q;
  logic [1:0]         mem_to_reg_q;
  logic [2:0]         bhw_q;
  halt_state_e        state_q;
  logic [INST_SZ-1:0] load_data;
  logic [INST_SZ-1:0] write_data_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= WB_ALU;
      bhw_q        <= '0;
      state_q      <= ST_RUN;
    end else if (bus.i_enable && state_q == ST_RUN) begin
      if (bus.i_flush) begin
        alu_result_q <= '0;
        read_data_q  <= '0;
        pc_plus4_q   <= '0;
        rd_q         <= '0;
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= WB_ALU;
        bhw_q        <= '0;
      end else begin
        alu_result_q <= bus.i_alu_result_M;
        read_data_q  <= bus.i_read_data_M;
        pc_plus4_q   <= bus.i_pc_plus4_M;
        rd_q         <= bus.i_rd_M;
        // the HALT instruction itself never writes the register file
        reg_write_q  <= bus.i_reg_write_M & ~bus.i_halt_M;
        mem_to_reg_q <= bus.i_mem_to_reg_M;
        bhw_q        <= bus.i_bhw_M;
        if (bus.i_halt_M) begin
          state_q <= ST_HALTED;
        end
      end
    end
  end

  load_extend #(.INST_SZ(INST_SZ)) u_load_extend (
    .word_i (read_data_q),
    .lane_i (alu_result_q[1:0]),
    .bhw_i  (bhw_q),
    .ext_o  (load_data)
  );

  always_comb begin
    write_data_d = alu_result_q;
    case (mem_to_reg_q)
      WB_MEM:  write_data_d = load_data;
      WB_PC4:  write_data_d = pc_plus4_q;
      default: write_data_d = alu_result_q;
    endcase
  end

  assign bus.o_write_data_W = write_data_d;
  assign bus.o_rd_W         = rd_q;
  assign bus.o_reg_write_W  = reg_write_q & (rd_q != '0) & (state_q == ST_RUN);
  assign bus.o_halt_W       = (state_q == ST_HALTED);

endmodule
